// File: rtl/inst_fetch_unit.sv
// Instruction fetch: owns the fetch PC, issues credit-limited in-order imem requests, buffers responses.
// Latency gnt@t, rvalid@t+k -> inst_valid@t+k+1; decode stalls hold the FIFO, and imem_req drops when buffer+in-flight reach depth.
module inst_fetch_unit #(
  parameter int                    instruction_width = 32,
  parameter int                    addr_width        = 32,
  parameter int                    fifo_depth        = 4,
  parameter logic [addr_width-1:0] reset_pc          = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         redirect_valid,
  input  logic [addr_width-1:0]        redirect_pc,
  output logic                         imem_req,
  output logic [addr_width-1:0]        imem_addr,
  input  logic                         imem_gnt,
  input  logic                         imem_rvalid,
  input  logic [instruction_width-1:0] imem_rdata,
  output logic                         inst_valid,
  input  logic                         inst_ready,
  output logic [instruction_width-1:0] inst_data,
  output logic [addr_width-1:0]        inst_pc
);
  localparam int PW = (fifo_depth > 1) ? $clog2(fifo_depth) : 1;
  localparam int CW = $clog2(fifo_depth + 1);

  typedef enum logic [1:0] {S_BOOT, S_RUN, S_STALL, S_FLUSH} state_t;

  state_t                       r_state, w_state_nxt;
  logic [addr_width-1:0]        r_fetch_pc;
  logic [CW-1:0]                r_occ, r_out, r_stale;
  logic [CW-1:0]                w_occ_nxt, w_out_nxt, w_stale_nxt;
  logic [PW-1:0]                r_wr_ptr, r_rd_ptr, r_tag_wr, r_tag_rd;
  logic [addr_width-1:0]        r_buf_pc  [fifo_depth];
  logic [instruction_width-1:0] r_buf_dat [fifo_depth];
  logic [addr_width-1:0]        r_tag     [fifo_depth];
  logic [CW:0]                  w_used, w_used_nxt;
  logic                         w_credit, w_credit_nxt;
  logic                         w_grant, w_rsp_push, w_rsp_drop, w_rsp, w_pop;

  // Credit counts buffered words plus words still in flight, so a push always finds room.
  assign w_used       = {1'b0, r_occ} + {1'b0, r_out};
  assign w_credit     = w_used < (CW+1)'(fifo_depth);
  assign imem_req     = (r_state == S_RUN) && w_credit;
  assign imem_addr    = r_fetch_pc;
  assign w_grant      = imem_req && imem_gnt;
  assign w_rsp_drop   = imem_rvalid && (r_stale != '0);
  assign w_rsp_push   = imem_rvalid && (r_stale == '0) && (r_out != '0);
  assign w_rsp        = w_rsp_drop || w_rsp_push;
  assign inst_valid   = (r_occ != '0);
  assign w_pop        = inst_valid && inst_ready;
  assign inst_data    = inst_valid ? r_buf_dat[r_rd_ptr] : '0;
  assign inst_pc      = inst_valid ? r_buf_pc[r_rd_ptr] : '0;
  assign w_used_nxt   = {1'b0, w_occ_nxt} + {1'b0, w_out_nxt};
  assign w_credit_nxt = w_used_nxt < (CW+1)'(fifo_depth);

  always_comb begin
    w_occ_nxt   = r_occ + CW'(w_rsp_push) - CW'(w_pop);
    w_out_nxt   = r_out + CW'(w_grant) - CW'(w_rsp_push);
    w_stale_nxt = r_stale - CW'(w_rsp_drop);
    if (redirect_valid) begin
      // Everything in flight, including this cycle's grant, becomes stale; older stale words drain first.
      w_occ_nxt   = '0;
      w_out_nxt   = '0;
      w_stale_nxt = r_stale + r_out + CW'(w_grant) - CW'(w_rsp);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_BOOT:         w_state_nxt = S_RUN;
      S_RUN, S_STALL: w_state_nxt = w_credit_nxt ? S_RUN : S_STALL;
      S_FLUSH:        if (w_stale_nxt == '0) w_state_nxt = S_RUN;
      default:        w_state_nxt = S_BOOT;
    endcase
    if (redirect_valid) w_state_nxt = (w_stale_nxt != '0) ? S_FLUSH : S_RUN;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_BOOT;
      r_fetch_pc <= reset_pc;
      r_occ      <= '0;
      r_out      <= '0;
      r_stale    <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_tag_wr   <= '0;
      r_tag_rd   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_occ   <= w_occ_nxt;
      r_out   <= w_out_nxt;
      r_stale <= w_stale_nxt;
      if (redirect_valid) begin
        r_fetch_pc <= redirect_pc & ~addr_width'(3);
        r_wr_ptr   <= '0;
        r_rd_ptr   <= '0;
        r_tag_wr   <= '0;
        r_tag_rd   <= '0;
      end else begin
        if (w_grant) begin
          r_fetch_pc <= r_fetch_pc + addr_width'(4);
          r_tag_wr   <= r_tag_wr + PW'(1);
        end
        if (w_rsp_push) begin
          r_tag_rd <= r_tag_rd + PW'(1);
          r_wr_ptr <= r_wr_ptr + PW'(1);
        end
        if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!redirect_valid && w_grant) r_tag[r_tag_wr] <= r_fetch_pc;
    if (!redirect_valid && w_rsp_push) begin
      r_buf_pc[r_wr_ptr]  <= r_tag[r_tag_rd];
      r_buf_dat[r_wr_ptr] <= imem_rdata;
    end
  end

  a_rvalid_has_request: assert property (@(posedge clk) disable iff (rst)
    imem_rvalid |-> (r_out != '0 || r_stale != '0));

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Bench for inst_fetch_unit: redirect vector table, directed latency/credit/flush/reset sequences,
// and randomized traffic checked against an in-order "expected PC stream" model.
module tb_inst_fetch_unit;
  localparam int AW = 32;
  localparam int IW = 32;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          redirect_valid = 1'b0;
  logic [AW-1:0] redirect_pc = '0;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_gnt = 1'b0;
  logic          imem_rvalid = 1'b0;
  logic [IW-1:0] imem_rdata = '0;
  logic          inst_valid;
  logic          inst_ready = 1'b0;
  logic [IW-1:0] inst_data;
  logic [AW-1:0] inst_pc;

  always #5 clk = ~clk;

  inst_fetch_unit #(
    .instruction_width(IW), .addr_width(AW), .fifo_depth(DEPTH), .reset_pc('0)
  ) dut (
    .clk(clk), .rst(rst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst_data(inst_data), .inst_pc(inst_pc)
  );

  typedef struct { logic [31:0] addr; int due; } mreq_t;
  typedef struct { logic [31:0] rpc; logic [31:0] exp_addr; logic [31:0] exp_next; } vec_t;

  mreq_t       mq[$];
  vec_t        vecs[6];
  int          n_checks = 0, n_pass = 0;
  int          cyc, lat_min = 1, lat_max = 1, gnt_pct = 0, ready_pct = 0, redir_pct = 0;
  int          n_gnt, n_deliv, n_req, first_valid, waited;
  logic [31:0] data_key = '0, force_rpc = '0, m_fetch_pc, exp_pc, first_deliv_pc;
  bit          force_redir = 0, prev_hold = 0, prev_redir = 0, did_gnt = 0, did_rvalid = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // One cycle: sample DUT at negedge, check against the model, then drive next inputs.
  task automatic step();
    bit g, r, rd, rv;
    logic [31:0] rpc;
    int lat;
    @(negedge clk);
    cyc++;
    if (inst_valid && first_valid < 0) first_valid = cyc;
    if (imem_req) begin
      n_req++;
      check("fetch_addr", imem_addr, m_fetch_pc);
    end
    if (prev_hold) check("req_held", imem_req, 1);
    if (prev_redir) check("valid_after_redirect", inst_valid, 0);
    rv = 0;
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      rv = 1;
      imem_rdata = mq[0].addr ^ data_key;
      void'(mq.pop_front());
    end
    g = imem_req && ($urandom_range(99) < gnt_pct);
    if (g) begin
      lat = $urandom_range(lat_max, lat_min);
      mq.push_back('{addr: imem_addr, due: cyc + lat});
    end
    r   = ($urandom_range(99) < ready_pct);
    rd  = force_redir || ($urandom_range(99) < redir_pct);
    rpc = force_redir ? force_rpc : ($urandom & 32'h0000_0FFF);
    force_redir = 0;
    if (inst_valid && r) begin
      check("inst_pc", inst_pc, exp_pc);
      check("inst_data", inst_data, exp_pc ^ data_key);
      if (n_deliv == 0) first_deliv_pc = inst_pc;
      exp_pc += 32'd4;
      n_deliv++;
    end
    if (g) begin
      m_fetch_pc += 32'd4;
      n_gnt++;
    end
    if (rd) begin
      m_fetch_pc = rpc & ~32'h3;
      exp_pc     = m_fetch_pc;
    end
    prev_hold  = imem_req && !g && !rd;
    prev_redir = rd;
    did_gnt    = g;
    did_rvalid = rv;
    imem_gnt = g; imem_rvalid = rv; inst_ready = r; redirect_valid = rd; redirect_pc = rpc;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    imem_gnt = 0; imem_rvalid = 0; redirect_valid = 0; inst_ready = 0; imem_rdata = '0;
    mq.delete();
    m_fetch_pc = '0; exp_pc = '0; prev_hold = 0; prev_redir = 0;
    #1;
    check("rst_req", imem_req, 0);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_valid", inst_valid, 0);
    check("rst_data", inst_data, 32'h0);
    check("rst_pc", inst_pc, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    cyc = 0; first_valid = -1; n_gnt = 0; n_deliv = 0; n_req = 0; first_deliv_pc = '1;
  endtask

  initial begin
    vecs[0] = '{rpc: 32'h0000_0203, exp_addr: 32'h0000_0200, exp_next: 32'h0000_0204};
    vecs[1] = '{rpc: 32'h0000_0100, exp_addr: 32'h0000_0100, exp_next: 32'h0000_0104};
    vecs[2] = '{rpc: 32'hFFFF_FFFE, exp_addr: 32'hFFFF_FFFC, exp_next: 32'h0000_0000};
    vecs[3] = '{rpc: 32'h0000_0001, exp_addr: 32'h0000_0000, exp_next: 32'h0000_0004};
    vecs[4] = '{rpc: 32'hDEAD_BEEF, exp_addr: 32'hDEAD_BEEC, exp_next: 32'hDEAD_BEF0};
    vecs[5] = '{rpc: 32'hFFFF_FFFC, exp_addr: 32'hFFFF_FFFC, exp_next: 32'h0000_0000};
    #2;

    // Streaming after reset: 1-cycle memory, rdata = pc, decode always ready.
    do_reset();
    data_key = '0; lat_min = 1; lat_max = 1; gnt_pct = 100; ready_pct = 100;
    repeat (12) step();
    check("first_valid_cycle", first_valid, 3);
    check("stream_grants", n_gnt, 12);
    check("stream_deliveries", n_deliv, 10);
    check("stream_first_pc", first_deliv_pc, 32'h0);

    // Decode stalled: credit limit, then one pop releases exactly one request.
    do_reset();
    data_key = 32'h5A5A_0F0F; gnt_pct = 100; ready_pct = 0;
    repeat (12) step();
    check("stall_grants", n_gnt, 4);
    check("stall_req_low", imem_req, 0);
    ready_pct = 100; step(); ready_pct = 0;
    repeat (10) step();
    check("pop_one_grant", n_gnt, 5);
    check("pop_one_deliv", n_deliv, 1);

    // Latency 5, three in flight, redirect: three drops, FLUSH, then 0x100.
    do_reset();
    lat_min = 5; lat_max = 5; gnt_pct = 100; ready_pct = 100;
    repeat (3) step();
    gnt_pct = 0; force_redir = 1; force_rpc = 32'h100;
    step();
    gnt_pct = 100; n_req = 0; n_deliv = 0; first_deliv_pc = '1;
    repeat (4) step();
    check("flush_no_req", n_req, 0);
    step();
    check("req_after_flush", n_req, 1);
    repeat (10) step();
    check("flush_first_pc", first_deliv_pc, 32'h100);

    // Redirect alignment and PC wrap table.
    lat_min = 1; lat_max = 3; gnt_pct = 0; ready_pct = 50;
    for (int i = 0; i < 6; i++) begin
      force_redir = 1; force_rpc = vecs[i].rpc;
      step();
      waited = 0;
      do begin step(); waited++; end while (!imem_req && waited < 20);
      check("redir_req", imem_req, 1);
      check("redir_addr", imem_addr, vecs[i].exp_addr);
      gnt_pct = 100; step(); gnt_pct = 0; step();
      check("addr_after_gnt", imem_addr, vecs[i].exp_next);
    end

    // Redirect coinciding with grant and response, then random traffic and credit-leak check.
    do_reset();
    lat_min = 2; lat_max = 2; gnt_pct = 100; ready_pct = 100;
    repeat (8) step();
    force_redir = 1; force_rpc = 32'h300;
    step();
    check("redir_gnt_rvalid", {did_gnt, did_rvalid}, 2'b11);
    n_deliv = 0; first_deliv_pc = '1;
    repeat (20) step();
    check("redir3_first_pc", first_deliv_pc, 32'h300);
    lat_min = 1; lat_max = 4; gnt_pct = 70; ready_pct = 60; redir_pct = 8;
    repeat (100) step();
    redir_pct = 0; gnt_pct = 0; ready_pct = 100;
    waited = 0;
    while ((mq.size() != 0 || inst_valid) && waited < 60) begin step(); waited++; end
    repeat (3) step();
    check("drained", (mq.size() == 0) && !inst_valid, 1);
    n_gnt = 0; ready_pct = 0; gnt_pct = 100;
    repeat (15) step();
    check("no_credit_leak", n_gnt, 4);
    check("credit_req_low", imem_req, 0);

    // Reset mid-burst: immediate reset outputs, restart from reset_pc.
    lat_min = 1; lat_max = 1; gnt_pct = 100; ready_pct = 100;
    repeat (6) step();
    do_reset();
    repeat (12) step();
    check("rerst_first_valid", first_valid, 3);
    check("rerst_first_pc", first_deliv_pc, 32'h0);
    check("rerst_deliveries", n_deliv, 10);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
